// File: rtl/micro_pkg.sv
// rtl/micro_pkg.sv - shared constants, microinstruction field map and FSM states
// Purpose: single source for the instruction/microinstruction layout used by
//          micro_sequencer and pc_unit.
// Ports:   none (package)
package micro_pkg;

  localparam int PC_W = 11;
  localparam int IW   = 22;
  localparam int MI_W = 33;

  localparam logic [IW-PC_W-1:0] JUMP_OP    = 11'b10000000000;
  localparam logic [MI_W-1:0]    MI_ILLEGAL = 33'd1;

  // Microinstruction field positions
  localparam int ALU_MSB   = 32;
  localparam int ALU_LSB   = 29;
  localparam int SH_MSB    = 28;
  localparam int SH_LSB    = 27;
  localparam int KMX       = 26;
  localparam int MR_BIT    = 25;
  localparam int MW_BIT    = 24;
  localparam int BUSB_MSB  = 23;
  localparam int BUSB_LSB  = 18;
  localparam int BUSC_MSB  = 17;
  localparam int BUSC_LSB  = 12;
  localparam int TWORD_MSB = 11;
  localparam int TWORD_LSB = 5;
  localparam int BUSA_MSB  = 4;
  localparam int BUSA_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    EXEC     = 3'd3,
    MEM_WAIT = 3'd4,
    HALT     = 3'd5
  } state_t;

  function automatic logic is_jump(input logic [IW-1:0] instr);
    return instr[IW-1:PC_W] == JUMP_OP;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with load, increment and natural wrap
// Purpose: holds the fetch address; load has priority over increment.
// Ports:   clk, rst   - clock, async active-high reset
//          load, inc  - one-cycle update strobes
//          load_val   - jump target
//          pc         - current program counter
module pc_unit
  import micro_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      // Wraps from all-ones to zero by width truncation
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - fetch/decode/execute controller for the microprogrammed datapath
// Purpose: fetches instructions, latches the ROM microinstruction into the MIR,
//          strobes execution, stalls on data memory ops, handles JUMP X and halts
//          on undecodable instructions.
// Ports:   clk, rst                         - clock, async active-high reset
//          run                              - level enable
//          imem_req/addr/ack/data           - instruction fetch handshake
//          rom_instr, rom_mi                - IR to ROM, ROM microinstruction back
//          mir, exec                        - registered microinstruction, execute strobe
//          dmem_req/we/ack                  - data memory handshake
//          pc, halted                       - program counter, sticky illegal flag
module micro_sequencer
  import micro_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_data,
  output logic [IW-1:0]   rom_instr,
  input  logic [MI_W-1:0] rom_mi,
  output logic [MI_W-1:0] mir,
  output logic            exec,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_t state, state_next;
  logic   pc_load, pc_inc;

  pc_unit u_pc_unit (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (rom_instr[PC_W-1:0]),
    .pc       (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes are decoded from state only, so an async reset clears them at once.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    exec       = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        // Ack wins over a simultaneous run drop
        if (imem_ack) state_next = DECODE;
      end
      DECODE: begin
        state_next = (rom_mi == MI_ILLEGAL) ? HALT : EXEC;
      end
      EXEC: begin
        exec = 1'b1;
        if (is_jump(rom_instr)) pc_load = 1'b1;
        else                    pc_inc  = 1'b1;
        if (mir[MR_BIT] || mir[MW_BIT]) state_next = MEM_WAIT;
        else                            state_next = run ? FETCH : IDLE;
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        // MR+MW together is treated as a write
        dmem_we  = mir[MW_BIT];
        if (dmem_ack) state_next = run ? FETCH : IDLE;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_instr <= '0;
      mir       <= '0;
      halted    <= 1'b0;
    end else begin
      if (state == FETCH && imem_ack) begin
        rom_instr <= imem_data;
      end
      if (state == DECODE) begin
        mir <= rom_mi;
        if (rom_mi == MI_ILLEGAL) halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed self-checking bench for micro_sequencer
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [10:0] imem_addr;
  logic        imem_ack;
  logic [21:0] imem_data;
  logic [21:0] rom_instr;
  logic [32:0] rom_mi;
  logic [32:0] mir;
  logic        exec;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [10:0] pc;
  logic        halted;

  int tests_run = 0;
  int tests_failed = 0;

  // {ALU,SH,Kmx,MR,MW,Bus_B,Bus_C,T_word,Bus_A}
  localparam logic [32:0] MI_JUMP  = {4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b100010, 7'b1000000, 5'd0};
  localparam logic [32:0] MI_PLAIN = {4'd3, 2'd1, 1'b1, 1'b0, 1'b0, 6'd1, 6'd2, 7'd3, 5'd4};
  localparam logic [32:0] MI_READ  = {4'd5, 2'd0, 1'b0, 1'b1, 1'b0, 6'd7, 6'd8, 7'd9, 5'd10};
  localparam logic [32:0] MI_RW    = {4'd6, 2'd2, 1'b0, 1'b1, 1'b1, 6'd11, 6'd12, 7'd13, 5'd14};

  always #5 clk = ~clk;

  // Microinstruction ROM model, combinational from the IR
  always_comb begin
    case (rom_instr)
      22'h200005: rom_mi = MI_JUMP;
      22'h000002: rom_mi = MI_READ;
      22'h000003: rom_mi = MI_RW;
      22'h3FFFFF: rom_mi = 33'd1;
      default:    rom_mi = MI_PLAIN;
    endcase
  end

  micro_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .rom_instr (rom_instr),
    .rom_mi    (rom_mi),
    .mir       (mir),
    .exec      (exec),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .pc        (pc),
    .halted    (halted)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in FETCH; presents one instruction for one cycle.
  task automatic serve(input logic [21:0] d);
    imem_ack  = 1'b1;
    imem_data = d;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_exec", exec, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_mir", mir, 0);
    check("rst_rom_instr", rom_instr, 0);
    check("rst_halted", halted, 0);

    // Reset in the middle of a fetch
    rst = 1'b0; run = 1'b1;
    @(negedge clk);
    check("fetch_req", imem_req, 1);
    #2 rst = 1'b1;
    #1 check("async_rst_req", imem_req, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_req", imem_req, 1);
    check("rel_addr", imem_addr, 0);

    // JUMP 5
    serve(22'h200005);
    check("dec_exec", exec, 0);
    check("dec_req", imem_req, 0);
    @(negedge clk);
    check("jmp_exec", exec, 1);
    check("jmp_mir", mir, MI_JUMP);
    check("jmp_exec_noreq", imem_req, 0);
    @(negedge clk);
    check("jmp_exec_pulse", exec, 0);
    check("jmp_req", imem_req, 1);
    check("jmp_addr", imem_addr, 5);

    // JUMP 2047, then a plain instruction wraps pc to 0
    serve(22'h2007FF);
    @(negedge clk);
    @(negedge clk);
    check("top_addr", imem_addr, 11'h7FF);
    serve(22'h000001);
    @(negedge clk);
    check("plain_exec", exec, 1);
    check("plain_mir", mir, MI_PLAIN);
    @(negedge clk);
    check("wrap_req", imem_req, 1);
    check("wrap_addr", imem_addr, 0);

    // Read with four stall cycles; stray imem_ack must be ignored
    serve(22'h000002);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("mr_dmem_req", dmem_req, 1);
      check("mr_dmem_we", dmem_we, 0);
      check("mr_noexec", exec, 0);
      check("mr_noimem", imem_req, 0);
      if (i < 3) begin
        imem_ack = 1'b1; imem_data = 22'h3FFFFF;
      end else begin
        imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b1;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    check("mr_done_dmem", dmem_req, 0);
    check("mr_next_req", imem_req, 1);
    check("mr_next_addr", imem_addr, 1);
    check("mr_ir_kept", rom_instr, 22'h000002);

    // MR and MW together behave as a write
    serve(22'h000003);
    @(negedge clk);
    @(negedge clk);
    check("rw_dmem_req", dmem_req, 1);
    check("rw_dmem_we", dmem_we, 1);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("rw_we_clr", dmem_we, 0);
    check("rw_next_addr", imem_addr, 2);
    check("rw_next_req", imem_req, 1);

    // run dropped during EXEC
    serve(22'h000001);
    @(negedge clk);
    check("rd_exec", exec, 1);
    run = 1'b0;
    @(negedge clk);
    check("rd_idle_req", imem_req, 0);
    check("rd_pc", pc, 3);
    @(negedge clk);
    check("rd_idle_req2", imem_req, 0);
    run = 1'b1;
    @(negedge clk);
    check("rd_resume_req", imem_req, 1);
    check("rd_resume_addr", imem_addr, 3);

    // ack and run drop together: instruction still captured and executed
    run = 1'b0;
    serve(22'h000004);
    check("ackrun_ir", rom_instr, 22'h000004);
    @(negedge clk);
    check("ackrun_exec", exec, 1);
    @(negedge clk);
    check("ackrun_idle", imem_req, 0);
    check("ackrun_pc", pc, 4);
    run = 1'b1;
    @(negedge clk);
    check("ackrun_addr", imem_addr, 4);

    // Illegal instruction halts
    serve(22'h3FFFFF);
    check("ill_dec_halted", halted, 0);
    @(negedge clk);
    check("ill_halted", halted, 1);
    check("ill_mir", mir, 1);
    for (int i = 0; i < 4; i++) begin
      check("ill_noexec", exec, 0);
      check("ill_noreq", imem_req, 0);
      @(negedge clk);
    end
    check("ill_pc", pc, 4);
    rst = 1'b1;
    #1 check("ill_rst_halted", halted, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ill_restart_req", imem_req, 1);
    check("ill_restart_addr", imem_addr, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
